// File: rtl/tube_readout_pkg.sv
// Shared constants for the tube readout block: FSM encoding,
// frame header byte and the byte-index width of a frame.
package tube_readout_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_WINDOW  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Wide enough to index NUM_TUBES+3 bytes for up to 32 tubes
  localparam int TUBE_CNT_W = 6;
endpackage

// File: rtl/tube_frame_tx.sv
// Frame serializer: header, event number, tube bytes, XOR checksum,
// presented on a valid/ready holding register.
module tube_frame_tx
  import tube_readout_pkg::*;
#(
  parameter int NUM_TUBES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [NUM_TUBES*8-1:0] snap_i,
  input  logic [7:0]             evt_i,
  input  logic                   out_ready_i,
  output logic [7:0]             out_data_o,
  output logic                   out_valid_o,
  output logic                   done_o
);
  localparam logic [TUBE_CNT_W-1:0] LAST = TUBE_CNT_W'(NUM_TUBES + 2);

  logic [TUBE_CNT_W-1:0] idx_q, idx_d, nxt;
  logic [7:0]            data_q, data_d;
  logic [7:0]            csum_q, csum_d;
  logic [7:0]            nxt_byte;
  logic                  valid_q, valid_d;
  logic                  xfer;

  assign xfer = valid_q && out_ready_i;
  assign nxt  = idx_q + TUBE_CNT_W'(1);

  // Checksum byte falls out as the default: running XOR plus last tube
  always_comb begin
    nxt_byte = csum_q ^ data_q;
    if (nxt == TUBE_CNT_W'(1))
      nxt_byte = evt_i;
    for (int i = 0; i < NUM_TUBES; i++)
      if (nxt == TUBE_CNT_W'(i + 2))
        nxt_byte = snap_i[8*i +: 8];
  end

  always_comb begin
    idx_d   = idx_q;
    data_d  = data_q;
    csum_d  = csum_q;
    valid_d = valid_q;
    if (start_i) begin
      idx_d   = '0;
      data_d  = FRAME_HDR;
      csum_d  = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      if (idx_q == LAST) begin
        valid_d = 1'b0;
        data_d  = '0;
      end else begin
        idx_d  = nxt;
        data_d = nxt_byte;
        if (idx_q != '0)
          csum_d = csum_q ^ data_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      data_q  <= '0;
      csum_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
      valid_q <= valid_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign done_o      = xfer && (idx_q == LAST);
endmodule

// File: rtl/tube_readout.sv
// Tube readout sequencer: clear, gate window, capture, then stream
// one frame per trigger; counts triggers that arrive while busy.
module tube_readout
  import tube_readout_pkg::*;
#(
  parameter int NUM_TUBES     = 8,
  parameter int WINDOW_CYCLES = 200
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   trigger,
  input  logic [NUM_TUBES*8-1:0] tube_data,
  input  logic                   out_ready,
  output logic                   tube_clr,
  output logic                   gate_enable,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic                   busy,
  output logic [7:0]             missed_triggers
);
  logic [2:0]             state_q, state_d;
  logic [7:0]             win_q, win_d;
  logic [7:0]             evt_q, evt_d;
  logic [7:0]             miss_q, miss_d;
  logic [NUM_TUBES*8-1:0] snap_q, snap_d;
  logic                   tclr_q, gate_q, busy_q;
  logic                   tx_done;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    evt_d   = evt_q;
    snap_d  = snap_q;
    case (state_q)
      S_IDLE:
        if (trigger) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d = S_WINDOW;
        win_d   = 8'(WINDOW_CYCLES - 1);
      end
      S_WINDOW:
        if (win_q == '0) state_d = S_CAPTURE;
        else             win_d   = win_q - 8'd1;
      S_CAPTURE: begin
        snap_d  = tube_data;
        state_d = S_SEND;
      end
      S_SEND:
        if (tx_done) begin
          state_d = S_IDLE;
          evt_d   = evt_q + 8'd1;
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    miss_d = miss_q;
    if (trigger && state_q != S_IDLE && miss_q != 8'hFF)
      miss_d = miss_q + 8'd1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      evt_q   <= '0;
      miss_q  <= '0;
      snap_q  <= '0;
      tclr_q  <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      evt_q   <= evt_d;
      miss_q  <= miss_d;
      snap_q  <= snap_d;
      tclr_q  <= (state_d == S_CLEAR);
      gate_q  <= (state_d == S_WINDOW);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  tube_frame_tx #(
    .NUM_TUBES(NUM_TUBES)
  ) u_tx (
    .clk        (clk),
    .rst        (clr),
    .start_i    (state_q == S_CAPTURE),
    .snap_i     (snap_d),
    .evt_i      (evt_q),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .done_o     (tx_done)
  );

  assign tube_clr        = tclr_q;
  assign gate_enable     = gate_q;
  assign busy            = busy_q;
  assign missed_triggers = miss_q;
endmodule

// File: tb/tb_tube_readout.sv
// Bench for tube_readout: timeline-based reference model checked
// every cycle, plus literal frame/counter expectations.
module tb_tube_readout;
  localparam int N = 4;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         clr;
  logic         trigger;
  logic         out_ready;
  logic [N*8-1:0] tube_data;
  logic         tube_clr, gate_enable, out_valid, busy;
  logic [7:0]   out_data, missed_triggers;

  int checks = 0;
  int failures = 0;

  bit         m_act = 1'b0;
  int         m_c = 0;
  int         m_k = 0;
  int         m_ms = 0;
  logic [7:0] m_evt = 8'd0;
  logic [7:0] m_frame [0:N+2];
  int         frames_done = 0;
  int         gate_cnt = 0;
  int         clr_cnt = 0;
  logic [7:0] rx [$];

  tube_readout #(
    .NUM_TUBES(N),
    .WINDOW_CYCLES(W)
  ) dut (
    .clk            (clk),
    .clr            (clr),
    .trigger        (trigger),
    .tube_data      (tube_data),
    .out_ready      (out_ready),
    .tube_clr       (tube_clr),
    .gate_enable    (gate_enable),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .busy           (busy),
    .missed_triggers(missed_triggers)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted trigger opens a timeline. Cycle 0 clear,
  // 1..W gate, W+1 capture, W+2 onward the frame streams out.
  always @(negedge clk) begin
    if (clr) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_missed", 32'(missed_triggers), 32'd0);
      m_act = 1'b0;
      m_ms  = 0;
      m_evt = 8'd0;
    end else begin
      chk("busy", 32'(busy), 32'(m_act));
      chk("tube_clr", 32'(tube_clr), 32'(m_act && m_c == 0));
      chk("gate", 32'(gate_enable), 32'(m_act && m_c >= 1 && m_c <= W));
      chk("valid", 32'(out_valid), 32'(m_act && m_c >= W + 2));
      if (m_act && m_c >= W + 2)
        chk("data", 32'(out_data), 32'(m_frame[m_k]));
      chk("missed", 32'(missed_triggers), 32'(m_ms));
      if (tube_clr) clr_cnt++;
      if (gate_enable) gate_cnt++;
      if (out_valid && out_ready) rx.push_back(out_data);
      if (!m_act) begin
        if (trigger) begin
          m_act = 1'b1;
          m_c   = 0;
          m_k   = 0;
        end
      end else begin
        if (trigger && m_ms < 255) m_ms++;
        if (m_c == W + 1) begin
          logic [7:0] cs;
          cs = m_evt;
          m_frame[0] = 8'hA5;
          m_frame[1] = m_evt;
          for (int i = 0; i < N; i++) begin
            m_frame[i+2] = tube_data[8*i +: 8];
            cs = cs ^ tube_data[8*i +: 8];
          end
          m_frame[N+2] = cs;
        end
        if (m_c >= W + 2 && out_ready) begin
          m_k++;
          if (m_k == N + 3) begin
            m_act = 1'b0;
            m_evt = m_evt + 8'd1;
            frames_done++;
          end
        end
        m_c++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic pulse_trig();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic wait_frame(input int start, input int budget);
    for (int i = 0; i < budget && frames_done == start; i++)
      step();
    chk("frame_timeout", 32'(frames_done - start), 32'd1);
  endtask

  task automatic chk_frame(input string nm, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e6);
    logic [7:0] exp [0:6];
    exp = '{e0, e1, 8'h01, 8'h02, 8'h03, 8'h04, e6};
    chk({nm, "_len"}, 32'(rx.size()), 32'd7);
    if (rx.size() == 7)
      for (int i = 0; i < 7; i++)
        chk({nm, "_byte"}, 32'(rx[i]), 32'(exp[i]));
  endtask

  initial begin
    int start;
    clr       = 1'b1;
    trigger   = 1'b0;
    out_ready = 1'b1;
    tube_data = 32'h04030201;
    step();
    step();
    chk("reset_tube_clr", 32'(tube_clr), 32'd0);
    chk("reset_gate", 32'(gate_enable), 32'd0);
    clr = 1'b0;

    // Basic frame, continuous ready
    rx.delete();
    gate_cnt = 0;
    clr_cnt  = 0;
    start    = frames_done;
    pulse_trig();
    wait_frame(start, 100);
    chk_frame("frame_basic", 8'hA5, 8'h00, 8'h04);
    chk("gate_cycles", 32'(gate_cnt), 32'd10);
    chk("clr_cycles", 32'(clr_cnt), 32'd1);

    // Ready toggling every cycle
    pulse_clr();
    rx.delete();
    start = frames_done;
    pulse_trig();
    for (int i = 0; i < 200 && frames_done == start; i++) begin
      out_ready = ~out_ready;
      step();
    end
    out_ready = 1'b1;
    chk("toggle_done", 32'(frames_done - start), 32'd1);
    chk_frame("frame_toggle", 8'hA5, 8'h00, 8'h04);

    // Missed triggers while busy, then saturation
    pulse_clr();
    rx.delete();
    start = frames_done;
    pulse_trig();
    step();
    pulse_trig();
    step();
    pulse_trig();
    step();
    pulse_trig();
    wait_frame(start, 100);
    step();
    chk("missed_three", 32'(missed_triggers), 32'd3);
    chk("single_frame", 32'(frames_done - start), 32'd1);
    trigger = 1'b1;
    repeat (400) step();
    trigger = 1'b0;
    for (int i = 0; i < 100 && busy; i++) step();
    chk("missed_sat", 32'(missed_triggers), 32'd255);

    // Asynchronous clear on the third frame byte
    pulse_clr();
    rx.delete();
    pulse_trig();
    for (int i = 0; i < 100 && rx.size() < 2; i++) step();
    chk("third_byte_reached", 32'(rx.size()), 32'd2);
    #2 clr = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_data", 32'(out_data), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    step();
    clr = 1'b0;
    rx.delete();
    start = frames_done;
    pulse_trig();
    wait_frame(start, 100);
    chk_frame("frame_after_clr", 8'hA5, 8'h00, 8'h04);

    // Random traffic across event-number wrap, data changing in SEND
    pulse_clr();
    start = frames_done;
    for (int i = 0; i < 20000 && frames_done - start < 258; i++) begin
      trigger   = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tube_data = $urandom;
      step();
    end
    trigger   = 1'b0;
    out_ready = 1'b1;
    chk("random_frames", 32'(frames_done - start >= 258), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
